// File: rtl/core_pkg.sv
// Shared decode definitions for the core front end: RV32I opcodes, ALU
// operation encodings, immediate formats and small decode helpers.
package core_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU operation encodings seen by EX
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  // Assemble the 32-bit sign-extended immediate for the given format.
  function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_type_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // Map funct3 (plus instr[30]) to an ALU op. SUB only exists for register
  // operands; for immediates instr[30] is part of the immediate value.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic bit30,
                                                input logic is_reg);
    logic [3:0] op;
    case (funct3)
      3'd0:    op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = bit30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Purely combinational RV32I decoder: register usage, destination,
// immediate, ALU op and control flags for one instruction word.
module id_decoder
  import core_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               rs1_used,
  output logic               rs2_used,
  output logic [ADDR_W-1:0]  rs1,
  output logic [ADDR_W-1:0]  rs2,
  output logic [ADDR_W-1:0]  rd,
  output logic [DATA_W-1:0]  imm,
  output logic [3:0]         alu_op,
  output logic               is_load,
  output logic               is_store,
  output logic               is_branch,
  output logic               is_jump,
  output logic               wb_en,
  output logic               illegal
);

  logic [6:0]  opcode_s;
  imm_type_e   imm_sel_s;
  logic        has_rd_s;
  logic [31:0] imm32_s;
  logic [31:0] word_s;

  assign word_s   = 32'(instr);
  assign opcode_s = word_s[6:0];

  // Classify the opcode into register usage, immediate format and control flags
  always_comb begin
    imm_sel_s = IMM_NONE;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    has_rd_s  = 1'b0;
    alu_op    = ALU_ADD;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode_s)
      OP_LUI: begin
        imm_sel_s = IMM_U;
        has_rd_s  = 1'b1;
        alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm_sel_s = IMM_U;
        has_rd_s  = 1'b1;
      end
      OP_JAL: begin
        imm_sel_s = IMM_J;
        has_rd_s  = 1'b1;
        is_jump   = 1'b1;
      end
      OP_JALR: begin
        imm_sel_s = IMM_I;
        rs1_used  = 1'b1;
        has_rd_s  = 1'b1;
        is_jump   = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel_s = IMM_B;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        alu_op    = ALU_SUB;
        is_branch = 1'b1;
      end
      OP_LOAD: begin
        imm_sel_s = IMM_I;
        rs1_used  = 1'b1;
        has_rd_s  = 1'b1;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        imm_sel_s = IMM_S;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        is_store  = 1'b1;
      end
      OP_IMM: begin
        imm_sel_s = IMM_I;
        rs1_used  = 1'b1;
        has_rd_s  = 1'b1;
        alu_op    = alu_from_funct(word_s[14:12], word_s[30], 1'b0);
      end
      OP_REG: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        has_rd_s  = 1'b1;
        alu_op    = alu_from_funct(word_s[14:12], word_s[30], 1'b1);
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

  assign imm32_s = build_imm(word_s, imm_sel_s);
  assign imm     = DATA_W'($signed(imm32_s));

  // Unused source fields read as x0 so they can never raise a false hazard.
  assign rs1   = rs1_used ? ADDR_W'(word_s[19:15]) : {ADDR_W{1'b0}};
  assign rs2   = rs2_used ? ADDR_W'(word_s[24:20]) : {ADDR_W{1'b0}};
  assign rd    = has_rd_s ? ADDR_W'(word_s[11:7])  : {ADDR_W{1'b0}};
  assign wb_en = has_rd_s & (rd != {ADDR_W{1'b0}});

endmodule

// File: rtl/id_stage.sv
// Decode stage in front of the register file: drives read addresses
// combinationally, registers decoded control in step with the register
// file read data, and inserts one bubble on a load-use hazard.
module id_stage
  import core_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_pc,
  output logic               in_ready,
  input  logic               flush,
  input  logic               ex_stall,
  output logic               rf_en,
  output logic               rf_stall,
  output logic [ADDR_W-1:0]  rf_addr1,
  output logic [ADDR_W-1:0]  rf_addr2,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_imm,
  output logic [3:0]         out_alu_op,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_is_branch,
  output logic               out_is_jump,
  output logic               out_wb_en,
  output logic               out_illegal
);

  logic              dec_rs1_used_s;
  logic              dec_rs2_used_s;
  logic [ADDR_W-1:0] dec_rs1_s;
  logic [ADDR_W-1:0] dec_rs2_s;
  logic [ADDR_W-1:0] dec_rd_s;
  logic [DATA_W-1:0] dec_imm_s;
  logic [3:0]        dec_alu_op_s;
  logic              dec_is_load_s;
  logic              dec_is_store_s;
  logic              dec_is_branch_s;
  logic              dec_is_jump_s;
  logic              dec_wb_en_s;
  logic              dec_illegal_s;
  logic              hazard_s;
  logic              accept_s;

  id_decoder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .instr     (in_instr),
    .rs1_used  (dec_rs1_used_s),
    .rs2_used  (dec_rs2_used_s),
    .rs1       (dec_rs1_s),
    .rs2       (dec_rs2_s),
    .rd        (dec_rd_s),
    .imm       (dec_imm_s),
    .alu_op    (dec_alu_op_s),
    .is_load   (dec_is_load_s),
    .is_store  (dec_is_store_s),
    .is_branch (dec_is_branch_s),
    .is_jump   (dec_is_jump_s),
    .wb_en     (dec_wb_en_s),
    .illegal   (dec_illegal_s)
  );

  // The register file reads every cycle from whatever fetch presents.
  assign rf_addr1 = dec_rs1_s;
  assign rf_addr2 = dec_rs2_s;
  assign rf_en    = rst_n;
  assign rf_stall = ex_stall;

  // Load at the output whose destination feeds a used source of the incoming word
  always_comb begin
    hazard_s = 1'b0;
    if (out_valid && out_is_load && (out_rd != {ADDR_W{1'b0}})) begin
      hazard_s = ((out_rd == dec_rs1_s) && dec_rs1_used_s) ||
                 ((out_rd == dec_rs2_s) && dec_rs2_used_s);
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign in_ready = rst_n & ~ex_stall & ~hazard_s;
  assign accept_s = in_valid & in_ready;

  // Output register: reset, then flush > stall > bubble > accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= {DATA_W{1'b0}};
      out_rd        <= {ADDR_W{1'b0}};
      out_imm       <= {DATA_W{1'b0}};
      out_alu_op    <= 4'd0;
      out_is_load   <= 1'b0;
      out_is_store  <= 1'b0;
      out_is_branch <= 1'b0;
      out_is_jump   <= 1'b0;
      out_wb_en     <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ex_stall) begin
      out_valid <= out_valid;
    end else if (hazard_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept_s;
      if (accept_s) begin
        out_pc        <= in_pc;
        out_rd        <= dec_rd_s;
        out_imm       <= dec_imm_s;
        out_alu_op    <= dec_alu_op_s;
        out_is_load   <= dec_is_load_s;
        out_is_store  <= dec_is_store_s;
        out_is_branch <= dec_is_branch_s;
        out_is_jump   <= dec_is_jump_s;
        out_wb_en     <= dec_wb_en_s;
        out_illegal   <= dec_illegal_s;
      end
    end
  end

endmodule
